// File: rtl/vga_pkg.sv
// vga_pkg: standard video mode parameter sets and axis width helpers
package vga_pkg;
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
  } vga_mode_t;
  localparam vga_mode_t VGA_640x480  = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
  localparam vga_mode_t HD_1280x720  = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
  localparam vga_mode_t HD_1920x1080 = '{1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1, 1'b1};
  function automatic int unsigned axis_total(input int unsigned a, f, s, b);
    return a + f + s + b;
  endfunction
  function automatic int unsigned cw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel strobe in, sync/enable/coordinate timing out
interface vga_timing_gen_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9
);
  logic          i_pix_stb;
  logic          o_hs;
  logic          o_vs;
  logic          o_de;
  logic          o_active;
  logic          o_blanking;
  logic          o_line_start;
  logic          o_frame_start;
  logic          o_animate;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic [15:0]   o_frame;
  modport master (
    input  i_pix_stb,
    output o_hs, o_vs, o_de, o_active, o_blanking, o_line_start, o_frame_start, o_animate, o_x, o_y, o_frame
  );
  modport slave (
    output i_pix_stb,
    input  o_hs, o_vs, o_de, o_active, o_blanking, o_line_start, o_frame_start, o_animate, o_x, o_y, o_frame
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis - wrapping counter with sync and active decode
module vga_axis_counter import vga_pkg::*; #(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP),
  localparam int unsigned W     = cw(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         sync,
  output logic         act
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    last  = 32'(cnt_q) == TOTAL - 1;
    cnt_d = en ? (last ? '0 : cnt_q + W'(1)) : cnt_q;
    sync  = (32'(cnt_q) - (ACTIVE + FP) < SYNC) ? POL : ~POL;
    act   = 32'(cnt_q) < ACTIVE;
  end
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised video timing with letterbox window, event pulses and frame count
module vga_timing_gen import vga_pkg::*; #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned WIN_TOP    = 60,
  parameter int unsigned WIN_HEIGHT = 360
) (
  input logic              i_clk,
  input logic              i_rst,
  vga_timing_gen_if.master bus
);
  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = cw(H_TOTAL);
  localparam int unsigned VW      = cw(V_TOTAL);
  localparam int unsigned XW      = cw(H_ACTIVE);
  localparam int unsigned YW      = cw(WIN_HEIGHT);
  localparam int unsigned WIN_END = WIN_TOP + WIN_HEIGHT;
  if (WIN_END > V_ACTIVE || H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || WIN_HEIGHT == 0) begin : g_bad_mode
    $error("vga_timing_gen: window outside active area or zero-width timing parameter");
  end
  logic          stb;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, h_sync, h_act, v_last, v_sync, v_act;
  logic [31:0]   v_off;
  logic          stb_q, stb_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d, active_q, active_d, blank_q, blank_d;
  logic          ls_q, ls_d, fs_q, fs_d, anim_q, anim_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d, frame_q, frame_d;
  assign stb = bus.i_pix_stb;
  vga_axis_counter #(.ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)) u_h (
    .clk(i_clk), .rst(i_rst), .en(stb), .cnt(h_cnt), .last(h_last), .sync(h_sync), .act(h_act)
  );
  vga_axis_counter #(.ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)) u_v (
    .clk(i_clk), .rst(i_rst), .en(stb & h_last), .cnt(v_cnt), .last(v_last), .sync(v_sync), .act(v_act)
  );
  always_comb begin
    v_off       = 32'(v_cnt) - WIN_TOP;
    stb_d       = stb;
    hs_d        = h_sync;
    vs_d        = v_sync;
    de_d        = h_act & v_act;
    active_d    = de_d & (v_off < WIN_HEIGHT);
    blank_d     = ~de_d;
    ls_d        = stb_q & (h_cnt == '0);
    fs_d        = ls_d & (v_cnt == '0);
    anim_d      = stb_q & (32'(h_cnt) == H_ACTIVE) & (32'(v_cnt) == WIN_END - 1);
    x_d         = active_d ? XW'(h_cnt) : '0;
    y_d         = active_d ? YW'(v_off) : '0;
    frame_cnt_d = frame_cnt_q + 16'(stb & h_last & v_last);
    frame_d     = frame_cnt_q;
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      stb_q       <= 1'b0;
      hs_q        <= ~H_POL;
      vs_q        <= ~V_POL;
      de_q        <= 1'b1;
      active_q    <= WIN_TOP == 0;
      blank_q     <= 1'b0;
      ls_q        <= 1'b0;
      fs_q        <= 1'b0;
      anim_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      frame_q     <= '0;
    end else begin
      stb_q       <= stb_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      de_q        <= de_d;
      active_q    <= active_d;
      blank_q     <= blank_d;
      ls_q        <= ls_d;
      fs_q        <= fs_d;
      anim_q      <= anim_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      frame_q     <= frame_d;
    end
  assign bus.o_hs          = hs_q;
  assign bus.o_vs          = vs_q;
  assign bus.o_de          = de_q;
  assign bus.o_active      = active_q;
  assign bus.o_blanking    = blank_q;
  assign bus.o_line_start  = ls_q;
  assign bus.o_frame_start = fs_q;
  assign bus.o_animate     = anim_q;
  assign bus.o_x           = x_q;
  assign bus.o_y           = y_q;
  assign bus.o_frame       = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of a small letterboxed mode and a full-window positive-polarity mode
module tb_vga_timing_gen;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0;
  int checks = 0, errors = 0;
  int th, tv, step_no, fs_step, n_hs, n_vs, n_de, n_act, n_ls, n_fs, n_anim, n_wide;
  int hs_min, hs_max, vs_min, vs_max, anim_h, anim_v, first_v, first_y, last_x, last_y;
  int xy_bad, blank_bad, n_act_b, n_de_b, n_hs_b, n_vs_b, freeze_bad;
  logic [63:0] snap;
  always #5 clk = ~clk;
  vga_timing_gen_if #(.XW(4), .YW(3)) a ();
  vga_timing_gen_if #(.XW(4), .YW(4)) b ();
  assign a.i_pix_stb = stb;
  assign b.i_pix_stb = stb;
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .WIN_TOP(2), .WIN_HEIGHT(5)) dut_a (.i_clk(clk), .i_rst(rst), .bus(a.master));
  vga_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b1), .V_POL(1'b1), .WIN_TOP(0), .WIN_HEIGHT(10)) dut_b (.i_clk(clk), .i_rst(rst), .bus(b.master));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic clear_stats();
    {step_no, fs_step, n_hs, n_vs, n_de, n_act, n_ls, n_fs, n_anim, n_wide} = '0;
    {xy_bad, blank_bad, n_act_b, n_de_b, n_hs_b, n_vs_b, last_x, last_y, anim_h, anim_v} = '0;
    hs_min = 999; hs_max = -1; vs_min = 999; vs_max = -1; first_v = -1; first_y = -1;
  endtask
  task automatic step();
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    @(negedge clk);
    if (th == 23) begin
      th = 0;
      tv = (tv == 14) ? 0 : tv + 1;
    end else th++;
    step_no++;
    if (a.o_hs === 1'b0) begin n_hs++; hs_min = (th < hs_min) ? th : hs_min; hs_max = (th > hs_max) ? th : hs_max; end
    if (a.o_vs === 1'b0) begin n_vs++; vs_min = (tv < vs_min) ? tv : vs_min; vs_max = (tv > vs_max) ? tv : vs_max; end
    if (a.o_de === 1'b1) n_de++;
    if (a.o_blanking !== ~a.o_de) blank_bad++;
    if (a.o_active === 1'b1) begin
      n_act++;
      if (first_v < 0) begin first_v = tv; first_y = int'(a.o_y); end
      last_x = int'(a.o_x);
      last_y = int'(a.o_y);
      if (a.o_x !== 4'(th) || a.o_y !== 3'(tv - 2)) xy_bad++;
    end else if (a.o_x !== 4'd0 || a.o_y !== 3'd0) xy_bad++;
    if (a.o_line_start === 1'b1) n_ls++;
    if (a.o_frame_start === 1'b1) begin n_fs++; fs_step = step_no; end
    if (a.o_animate === 1'b1) begin n_anim++; anim_h = th; anim_v = tv; end
    if (b.o_active === 1'b1) n_act_b++;
    if (b.o_de === 1'b1) n_de_b++;
    if (b.o_hs === 1'b1) n_hs_b++;
    if (b.o_vs === 1'b1) n_vs_b++;
    @(negedge clk);
    if (a.o_line_start | a.o_frame_start | a.o_animate | b.o_line_start | b.o_frame_start | b.o_animate) n_wide++;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_hs", a.o_hs, 1);
    chk("rst_vs", a.o_vs, 1);
    chk("rst_de", a.o_de, 1);
    chk("rst_active", a.o_active, 0);
    chk("rst_blank", a.o_blanking, 0);
    chk("rst_xy", {a.o_x, a.o_y}, 0);
    chk("rst_pulses", {a.o_line_start, a.o_frame_start, a.o_animate}, 0);
    chk("rst_frame", a.o_frame, 0);
    chk("rst_b_active", b.o_active, 1);
    chk("rst_b_sync", {b.o_hs, b.o_vs}, 0);
    th = 0; tv = 0;
    clear_stats();
    repeat (360) step();
    chk("frame_start_count", n_fs, 1);
    chk("frame_start_step", fs_step, 360);
    chk("frame_after_one", a.o_frame, 1);
    chk("line_start_count", n_ls, 15);
    chk("pulse_width", n_wide, 0);
    chk("hs_low_count", n_hs, 45);
    chk("hs_low_first", hs_min, 18);
    chk("hs_low_last", hs_max, 20);
    chk("vs_low_count", n_vs, 48);
    chk("vs_low_first", vs_min, 11);
    chk("vs_low_last", vs_max, 12);
    chk("de_count", n_de, 160);
    chk("blanking_inv", blank_bad, 0);
    chk("active_count", n_act, 80);
    chk("first_active_v", first_v, 2);
    chk("first_active_y", first_y, 0);
    chk("last_x", last_x, 15);
    chk("last_y", last_y, 4);
    chk("xy_track", xy_bad, 0);
    chk("animate_count", n_anim, 1);
    chk("animate_h", anim_h, 16);
    chk("animate_v", anim_v, 6);
    chk("b_active_count", n_act_b, 160);
    chk("b_de_count", n_de_b, 160);
    chk("b_hs_high_count", n_hs_b, 45);
    chk("b_vs_high_count", n_vs_b, 48);
    chk("b_frame", b.o_frame, 1);
    repeat (5) step();
    chk("pre_freeze_x", b.o_x, 5);
    snap = {a.o_hs, a.o_vs, a.o_de, a.o_active, a.o_blanking, a.o_x, a.o_y, a.o_frame, b.o_x, b.o_y};
    freeze_bad = 0;
    repeat (50) begin
      @(negedge clk);
      if ({a.o_hs, a.o_vs, a.o_de, a.o_active, a.o_blanking, a.o_x, a.o_y, a.o_frame, b.o_x, b.o_y} !== snap[35:0] ||
          (a.o_line_start | a.o_frame_start | a.o_animate | b.o_line_start | b.o_frame_start | b.o_animate) !== 1'b0)
        freeze_bad++;
    end
    chk("freeze", freeze_bad, 0);
    step();
    chk("resume_x", b.o_x, 6);
    repeat (172) step();
    chk("mid_b_x", b.o_x, 10);
    chk("mid_b_y", b.o_y, 7);
    chk("mid_frame", a.o_frame, 1);
    rst = 1'b1;
    stb = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    stb = 1'b0;
    chk("mrst_frame", a.o_frame, 0);
    chk("mrst_levels", {a.o_hs, a.o_vs, a.o_de, a.o_active, a.o_blanking}, 5'b11100);
    chk("mrst_b_xy", {b.o_x, b.o_y, b.o_active}, 1);
    @(negedge clk);
    chk("mrst_no_pulse", {a.o_line_start, a.o_frame_start, a.o_animate, b.o_frame_start}, 0);
    chk("mrst_de_hold", {a.o_de, a.o_blanking}, 2'b10);
    th = 0; tv = 0;
    clear_stats();
    repeat (360) step();
    chk("mrst_fs_count", n_fs, 1);
    chk("mrst_fs_step", fs_step, 360);
    chk("mrst_frame_after", a.o_frame, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 timing core. Generates h/v sync, display-enable and pixel coordinates for any CEA/VESA-style mode from porch/sync/active parameters, with selectable sync polarity. Adds a programmable letterbox window, single-cycle line, frame and animate pulses, and a frame counter. Sits between the pixel-strobe generator and the framebuffer/sprite pipelines.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active low)
V_POL, 0, vsync asserted level
WIN_TOP, 60, first active line of letterbox window
WIN_HEIGHT, 360, window lines; WIN_TOP+WIN_HEIGHT <= V_ACTIVE
Derived localparams: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL); XW = $clog2(H_ACTIVE); YW = $clog2(WIN_HEIGHT).

Ports:
i_clk  in  1  system clock
i_rst  in  1  synchronous active-high reset; restarts frame
i_pix_stb  in  1  pixel-rate enable; counters advance only when high
o_hs  out  1  horizontal sync, level per H_POL
o_vs  out  1  vertical sync, level per V_POL
o_de  out  1  high in full H_ACTIVE x V_ACTIVE region
o_active  out  1  o_de AND line inside letterbox window
o_blanking  out  1  ~o_de
o_line_start  out  1  one-clock pulse on entering h=0
o_frame_start  out  1  one-clock pulse on entering h=0,v=0
o_animate  out  1  one-clock pulse on leaving last active pixel of last window line
o_x  out  XW  h_count while o_active, else 0
o_y  out  YW  v_count-WIN_TOP while o_active, else 0
o_frame  out  16  completed-frame count, wraps at 65535->0

Behaviour:
- Line order: active [0,H_ACTIVE), FP, sync [H_ACTIVE+H_FP, +H_SYNC), BP. Vertical identical in lines.
- On i_pix_stb: h_count increments; at H_TOTAL-1 wraps to 0 and v_count increments; v_count at V_TOTAL-1 with h wrap -> 0 and o_frame increments. No off-by-one: exactly H_TOTAL strobes/line, V_TOTAL lines/frame.
- i_pix_stb low: counters and level outputs hold; pulses low.
- All outputs registered: decoded from the counter value present after the edge; latency exactly 1 i_clk from counter update to outputs.
- Pulses qualified by registered strobe: high exactly one i_clk per event, independent of strobe ratio.
- o_animate fires when counters move from (H_ACTIVE-1, WIN_TOP+WIN_HEIGHT-1) to (H_ACTIVE, same line).
- Reset (priority over i_pix_stb, any point mid-frame): h_count=v_count=0, o_frame=0; next cycle o_hs=~H_POL, o_vs=~V_POL, o_de=1, o_active=(WIN_TOP==0), o_blanking=0, o_x=o_y=0, all pulses 0 (no frame_start pulse on reset itself).
- Coordinates never exceed H_ACTIVE-1 / WIN_HEIGHT-1.
- Elaboration error ($error in initial/generate) if window exceeds V_ACTIVE or any width param is 0.

Decomposition:
- Package vga_pkg: mode parameter sets as localparams (VGA_640x480, HD_1280x720, HD_1920x1080) and a helper function for total/width derivation.
- One sub-module natural: vga_axis_counter (count, wrap, sync/active decode for one axis), instanced for H (enable = strobe) and V (enable = strobe & h wrap).

Test Plan:
- Defaults, strobe every 4th clock, reset then run 1 frame -> exactly 800*525 strobes between o_frame_start pulses; each pulse 1 clock wide; o_frame 0->1.
- Defaults -> o_hs low for strobes h=656..751 (96); o_vs low on lines 490..491; o_de count per frame 307200.
- Defaults -> o_active count 230400; first at v=60,o_y=0; last o_x=639,o_y=359; o_animate once per frame at v=419,h=640.
- 1280x720 params (110/40/220, 5/5/20, H_POL=V_POL=1, WIN_TOP=0, WIN_HEIGHT=720) -> hs high strobes 1390..1429, 1650x750 total, o_active == o_de.
- Assert i_rst at v=300,h=400 -> next cycle counters 0, o_frame 0, outputs at reset values; next frame_start after 800*525 strobes.
- Strobe held low 50 clocks mid-line -> all outputs frozen, no pulses; resumes at same h.
